// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory answering CPU load/store requests
// with a fixed latency. Optional macro: DMEM_ALIGN_CHECK_EN (reject misaligned halfword/word).
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [7:0]        r_mem [DEPTH];

  logic [ADDR_W-1:0] w_addr [4];
  logic [7:0]        w_rbyte [4];
  logic [3:0]        w_be;
  logic [31:0]       w_load;
  logic              w_illegal;
  logic              w_access;
  logic              w_wr;

  // Byte lanes: lane k sits at addr+k, wrapping around the array
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_addr[k]  = r_addr + ADDR_W'(k);
      w_rbyte[k] = r_mem[w_addr[k]];
    end
  end

  // Size decode: lane enables, legality, and extended load value
  always_comb begin
    w_be      = 4'b0000;
    w_load    = 32'd0;
    w_illegal = 1'b0;
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001;
        w_load = {{24{r_signed & w_rbyte[0][7]}}, w_rbyte[0]};
      end
      2'b01: begin
        w_be   = 4'b0011;
        w_load = {{16{r_signed & w_rbyte[1][7]}}, w_rbyte[1], w_rbyte[0]};
      end
      2'b10: begin
        w_be   = 4'b1111;
        w_load = {w_rbyte[3], w_rbyte[2], w_rbyte[1], w_rbyte[0]};
      end
      default: begin
        w_be      = 4'b0000;
        w_load    = 32'd0;
        w_illegal = 1'b1;
      end
    endcase
`ifdef DMEM_ALIGN_CHECK_EN
    if ((r_size == 2'b01 && r_addr[0] != 1'b0) ||
        (r_size == 2'b10 && r_addr[1:0] != 2'b00)) begin
      w_illegal = 1'b1;
    end else begin
      w_illegal = w_illegal;
    end
`endif
  end

  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_wr     = w_access && r_we && !w_illegal;

  // Storage array; deliberately not reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_wr && w_be[k]) begin
        r_mem[w_addr[k]] <= r_wdata[8*k +: 8];
      end
    end
  end

  // Request/response FSM with latched request fields and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_cnt    <= 4'(WAIT_CYCLES);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RESP;
            r_err   <= w_illegal;
            r_rdata <= (w_illegal || r_we) ? 32'd0 : w_load;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, hand-written stall/reset
// sequences, and randomized traffic checked against a byte-array model.
module tb_data_mem_responder;

  localparam int WAITC = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] m_mem [256];

  data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [1:0] sz, logic sg, logic [7:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic er);
    vec_t v;
    v.we = we; v.sz = sz; v.sg = sg; v.addr = a; v.wd = wd;
    v.exp_rd = rd; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: bytes counted by size, little-endian, address modulo 256
  task automatic model_access(input logic we, input logic [1:0] sz, input logic sg,
                              input logic [7:0] a, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int nb;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    er = (nb == 0);
`ifdef DMEM_ALIGN_CHECK_EN
    if (nb > 1 && (int'(a) % nb) != 0) er = 1'b1;
`endif
    rd = 32'd0;
    if (!er) begin
      for (int k = 0; k < nb; k++) begin
        if (we) m_mem[(int'(a) + k) % 256] = wd[8*k +: 8];
        else    rd = rd | (32'(m_mem[(int'(a) + k) % 256]) << (8 * k));
      end
      if (!we && sg && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'd1 << (8 * nb)) - 32'd1);
    end
  endtask

  // One transaction; stall = cycles rsp_ready is held low once the response shows
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] wd, input int stall,
                         output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = 32'd0; er = 1'b0; lat = -1;
    @(negedge clk);
    rsp_ready = (stall == 0);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = $urandom_range(0, 1); req_addr = 8'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      rsp_ready = 1'b1;
    end
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, exp_rd, held;
  logic        er, exp_er;
  int          lat;
  int          r;
  logic [1:0]  sz;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 8'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    #3 reset = 1'b1;
    #1;
    chk("reset_flags", {29'd0, req_ready, rsp_valid, rsp_err}, 32'd4);
    chk("reset_rdata", rsp_rdata, 32'd0);

    // Fill the whole array so every later load has a known expectation
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      model_access(1'b1, 2'd2, 1'b0, 8'(i * 4), w, exp_rd, exp_er);
      run_txn(1'b1, 2'd2, 1'b0, 8'(i * 4), w, 0, rd, er, lat);
    end

    tbl.push_back(mk(1, 2'd2, 0, 8'h10, 32'hDEADBEEF, 32'h0, 0));
    tbl.push_back(mk(0, 2'd2, 0, 8'h10, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 2'd0, 1, 8'h13, 32'h0, 32'hFFFFFFDE, 0));
    tbl.push_back(mk(0, 2'd0, 0, 8'h13, 32'h0, 32'h000000DE, 0));
    tbl.push_back(mk(0, 2'd1, 1, 8'h12, 32'h0, 32'hFFFFDEAD, 0));
    tbl.push_back(mk(0, 2'd1, 0, 8'h10, 32'h0, 32'h0000BEEF, 0));
    tbl.push_back(mk(1, 2'd0, 0, 8'h11, 32'h123456FF, 32'h0, 0));
    tbl.push_back(mk(1, 2'd0, 0, 8'h12, 32'hAABBCC00, 32'h0, 0));
    tbl.push_back(mk(1, 2'd0, 0, 8'h13, 32'h55555501, 32'h0, 0));
    tbl.push_back(mk(1, 2'd0, 0, 8'h14, 32'hFFFFFF02, 32'h0, 0));
`ifdef DMEM_ALIGN_CHECK_EN
    tbl.push_back(mk(0, 2'd2, 0, 8'h11, 32'h0, 32'h0, 1));
`else
    tbl.push_back(mk(0, 2'd2, 0, 8'h11, 32'h0, 32'h020100FF, 0));
`endif
    tbl.push_back(mk(0, 2'd2, 0, 8'h10, 32'h0, 32'h0100FFEF, 0));
    tbl.push_back(mk(1, 2'd3, 0, 8'h10, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 2'd2, 0, 8'h10, 32'h0, 32'h0100FFEF, 0));
    tbl.push_back(mk(0, 2'd1, 1, 8'h10, 32'h0, 32'hFFFFFFEF, 0));
`ifdef DMEM_ALIGN_CHECK_EN
    tbl.push_back(mk(1, 2'd1, 0, 8'h11, 32'h0000ABCD, 32'h0, 1));
    tbl.push_back(mk(0, 2'd2, 0, 8'h10, 32'h0, 32'h0100FFEF, 0));
`else
    tbl.push_back(mk(1, 2'd1, 0, 8'h11, 32'h0000ABCD, 32'h0, 0));
    tbl.push_back(mk(0, 2'd2, 0, 8'h10, 32'h0, 32'h01ABCDEF, 0));
`endif
    tbl.push_back(mk(0, 2'd3, 1, 8'h20, 32'h0, 32'h0, 1));

    foreach (tbl[i]) begin
      model_access(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, exp_rd, exp_er);
      run_txn(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd, 0, rd, er, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(WAITC + 1));
    end

    // Word load straddling the top of the address space
    model_access(1'b0, 2'd2, 1'b0, 8'hFF, 32'd0, exp_rd, exp_er);
    run_txn(1'b0, 2'd2, 1'b0, 8'hFF, 32'd0, 0, rd, er, lat);
    chk("wrap_rdata", rd, exp_rd);
    chk("wrap_err", {31'd0, er}, {31'd0, exp_er});

    // Back-pressure: response held for 5 cycles
    model_access(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, exp_rd, exp_er);
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 8'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    held = rsp_rdata;
    chk("bp_rdata", held, exp_rd);
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", c), {rsp_valid, req_ready, 30'd0, rsp_rdata == held},
          {1'b1, 1'b0, 30'd0, 1'b1});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Reset while a store waits: memory must be untouched
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 8'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wait_flags", {29'd0, req_ready, rsp_valid, rsp_err}, 32'd4);
    chk("rst_wait_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_access(1'b0, 2'd2, 1'b0, 8'h20, 32'd0, exp_rd, exp_er);
    run_txn(1'b0, 2'd2, 1'b0, 8'h20, 32'd0, 0, rd, er, lat);
    chk("rst_wait_mem", rd, exp_rd);
    run_txn(1'b0, 2'd3, 1'b0, 8'h20, 32'd0, 0, rd, er, lat);
    chk("rst_illegal_err", {31'd0, er}, 32'd1);

    // Reset while a nonzero response is pending
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 8'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("rst_resp_pre", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_resp_flags", {29'd0, req_ready, rsp_valid, rsp_err}, 32'd4);
    chk("rst_resp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1; rsp_ready = 1'b1;

    // Randomized traffic against the model, with occasional response stalls
    for (int i = 0; i < 300; i++) begin
      logic        we, sg;
      logic [7:0]  a;
      logic [31:0] wd;
      int          st;
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      we = $urandom_range(0, 1);
      sg = $urandom_range(0, 1);
      a  = 8'($urandom);
      wd = $urandom;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      model_access(we, sz, sg, a, wd, exp_rd, exp_er);
      run_txn(we, sz, sg, a, wd, st, rd, er, lat);
      chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, exp_er});
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(WAITC + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
